// File: rtl/risc_pkg.sv
// Shared constants and decode-state type for the RISC fetch/decode stage.
package risc_pkg;

  localparam int          RISC_OPC_W      = 4;
  localparam int          RISC_ADDR_W     = 5;
  localparam int          RISC_SHORT_W    = 4;
  // Opcodes 3, 6, 7, 8, 10 and 14 carry a short destination field.
  localparam logic [15:0] RISC_SHORT_MASK = 16'h45C8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    STALL = 2'd2
  } dec_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
// The lookup sees this edge's updates so a fetch agrees with the post-edge vector.
module reg_scoreboard
  import risc_pkg::*;
#(
  parameter int ADDR_W = RISC_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_i,
  input  logic [ADDR_W-1:0]    set_addr_i,
  input  logic                 clr_i,
  input  logic [ADDR_W-1:0]    clr_addr_i,
  input  logic [ADDR_W-1:0]    look_addr_i,
  output logic                 look_hit_o,
  output logic [2**ADDR_W-1:0] pending_o
);

  logic [2**ADDR_W-1:0] pend_q, pend_d;

  // Clear first so a same-address set wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    if (set_i) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(negedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign look_hit_o = pend_d[look_addr_i];
  assign pending_o  = pend_q;

endmodule

// File: rtl/reg_addr_decode.sv
// Destination-register address decoder with optional write-back hazard scoreboard.
// Define REG_ADDR_SCOREBOARD_EN to build the scoreboard, STALL state and hazard output.
module reg_addr_decode
  import risc_pkg::*;
#(
  parameter int                  OPC_W      = RISC_OPC_W,
  parameter int                  ADDR_W     = RISC_ADDR_W,
  parameter int                  SHORT_W    = RISC_SHORT_W,
  parameter logic [2**OPC_W-1:0] SHORT_MASK = RISC_SHORT_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_Fetch,
  input  logic [OPC_W-1:0]     I,
  input  logic [ADDR_W-1:0]    rd_field,
  input  logic                 en_Issue,
  input  logic                 wb_en,
  input  logic [ADDR_W-1:0]    wb_addr,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_short,
  output logic                 rd_valid,
  output logic                 issued,
  output logic                 hazard,
  output logic [2**ADDR_W-1:0] pending
);

  dec_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_short_q, rd_short_d;
  logic              issued_q, issued_d;

  logic              new_short;
  logic [ADDR_W-1:0] new_addr;
  logic              new_pend;
  logic              do_issue;
  logic              wb_hit;

  assign new_short = SHORT_MASK[I];
  assign new_addr  = new_short ? {{(ADDR_W-SHORT_W){1'b0}}, rd_field[SHORT_W-1:0]}
                               : rd_field;
  assign do_issue  = (state_q == HELD) && en_Issue;

`ifdef REG_ADDR_SCOREBOARD_EN
  assign wb_hit = wb_en && (wb_addr == rd_addr_q);

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_i       (do_issue),
    .set_addr_i  (rd_addr_q),
    .clr_i       (wb_en),
    .clr_addr_i  (wb_addr),
    .look_addr_i (new_addr),
    .look_hit_o  (new_pend),
    .pending_o   (pending)
  );

  // Same-cycle write-back to the held destination bypasses the stall.
  assign hazard = (state_q == STALL) && !wb_hit;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr};
  assign wb_hit    = 1'b0;
  assign new_pend  = 1'b0;
  assign pending   = '0;
  assign hazard    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_short_d = rd_short_q;
    issued_d   = 1'b0;

    unique case (state_q)
      IDLE: ;
      HELD: begin
        if (do_issue) begin
          issued_d = 1'b1;
          state_d  = IDLE;
        end
      end
      STALL: begin
        if (wb_hit) state_d = HELD;
      end
      default: state_d = IDLE;
    endcase

    // A fetch in any state replaces the held decode (redirect or issue+fetch).
    if (en_Fetch) begin
      rd_addr_d  = new_addr;
      rd_short_d = new_short;
      state_d    = new_pend ? STALL : HELD;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rd_short_q <= 1'b0;
      issued_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_short_q <= rd_short_d;
      issued_q   <= issued_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_short = rd_short_q;
  assign rd_valid = (state_q != IDLE);
  assign issued   = issued_q;

endmodule

// File: doc/reg_addr_decode.md
# reg_addr_decode

Parametrised destination-register address decoder for the RISC processor's fetch/decode stage. On each fetch it latches the opcode and raw destination field, zero-extends short-form destination fields to the full register-file address width, and holds the result until the instruction issues. An optional write-back scoreboard tracks destinations with writes in flight and flags read-after-write / write-after-write hazards to the control unit.

## Interface
- `OPC_W`, default 4: opcode width.
- `ADDR_W`, default 5: full register address width (2**ADDR_W registers).
- `SHORT_W`, default 4: destination field width for short-form opcodes; must be less than `ADDR_W`.
- `SHORT_MASK`, default 16'h45C8 (2**OPC_W bits): bit n set means opcode n carries a short destination field. The default marks opcodes 3, 6, 7, 8, 10 and 14.
- `clk` in 1: clock; all state updates on the falling edge.
- `rst` in 1: reset, synchronous, active-high, sampled on the falling edge.
- `en_Fetch` in 1: fetch strobe; latch `I` and `rd_field`.
- `I` in `OPC_W`: opcode from the instruction register.
- `rd_field` in `ADDR_W`: raw destination field from the instruction register.
- `en_Issue` in 1: control unit requests issue of the held instruction.
- `wb_en` in 1: write-back completing this cycle.
- `wb_addr` in `ADDR_W`: register being written back.
- `rd_addr` out `ADDR_W`: decoded destination address.
- `rd_short` out 1: held instruction is short-form.
- `rd_valid` out 1: a decoded instruction is held.
- `issued` out 1: one-cycle pulse; the held instruction issued on the last edge.
- `hazard` out 1: held destination has a write in flight.
- `pending` out 2**`ADDR_W`: scoreboard bit vector.

## Operation
- Decode uses `match = SHORT_MASK[I]`.
  - `match` = 1: `rd_addr` <= `rd_field[SHORT_W-1:0]`, zero-extended to `ADDR_W`.
  - `match` = 0: `rd_addr` <= `rd_field`.
- State machine, states IDLE, HELD, STALL. Reset enters IDLE.
- IDLE:
  - `en_Fetch` → HELD, or STALL if the new destination is pending.
- HELD:
  - `en_Issue` issues the instruction: set `pending[rd_addr]`, pulse `issued`.
  - After issue, go to IDLE; if `en_Fetch` is asserted on the same edge, decode the new instruction and go to HELD or STALL.
  - `en_Fetch` without `en_Issue` overwrites the held decode (fetch redirect). Nothing is set.
- STALL:
  - `en_Issue` is ignored; no pulse, no scoreboard change.
  - `wb_en` with `wb_addr == rd_addr` → HELD on that edge.
  - `en_Fetch` re-decodes the new instruction.
- `hazard` is combinational: (state == STALL) and not (`wb_en` and `wb_addr == rd_addr`). Write-back is bypassed in the same cycle.
- Scoreboard on each edge:
  - Write-back clears `pending[wb_addr]`.
  - Issue sets `pending[rd_addr]`.
  - When both hit the same address, the set wins.
- Addresses are unsigned. No wrap-around logic; indices are always in range.

## Timing
- Decode latency: `rd_addr`, `rd_short` and `rd_valid` change on the falling edge that samples `en_Fetch`.
- `issued`: high for exactly one cycle after the issuing edge.
- `pending` update: visible after the issuing or write-back edge.
- Without `en_Fetch`, `rd_addr` and `rd_short` hold their values indefinitely.
- Reset values: `rd_addr`=0, `rd_short`=0, `rd_valid`=0, `issued`=0, `hazard`=0, `pending`=0, state IDLE.
- Reset mid-operation discards the held instruction and all pending bits, even if `en_Issue` or `wb_en` is asserted on that edge.
- Simultaneous `rst` and `en_Fetch`: reset wins.

## Configuration
- `REG_ADDR_SCOREBOARD_EN` defined: scoreboard, STALL state and `hazard` logic are compiled in as described above.
- Macro undefined:
  - No scoreboard registers.
  - `pending` tied to 0 and `hazard` tied to 0.
  - STALL is unreachable; fetch always goes to HELD.
  - `wb_en` and `wb_addr` are unused.

## Structure
- Shared package `risc_pkg` holds:
  - the opcode width constant;
  - the short-form opcode mask constant (16'h45C8);
  - the register address width;
  - the state enum {IDLE, HELD, STALL}.
- One sub-module: `reg_scoreboard`, the pending vector with set/clear ports and a lookup output. Instantiated only under `REG_ADDR_SCOREBOARD_EN`.

## Test plan
- Fetch with `I`=4'b0011 and `rd_field`=5'b11010 → `rd_addr`=5'b01010, `rd_short`=1, `rd_valid`=1 after one edge. Repeat with `I`=4'b0001 → `rd_addr`=5'b11010, `rd_short`=0.
- Fetch `rd_field`=5, then `en_Issue` → `issued` pulses once, `pending[5]`=1, `rd_valid`=0.
- With `pending[5]` set, fetch `rd_field`=5 → `hazard`=1. `en_Issue` ignored for 3 cycles. `wb_en` with `wb_addr`=5 drops `hazard` in the same cycle; next `en_Issue` issues.
- Same edge: `en_Issue` for reg 9 and `wb_en` for reg 9 → `pending[9]`=1.
- Assert `rst` while in STALL with pending bits set → all outputs 0, state IDLE on the next edge.
- With `REG_ADDR_SCOREBOARD_EN` undefined, refetch a previously issued destination → `hazard`=0, issue is accepted.
